// File: rtl/fpu_rr_interconnect_if.sv
// fpu_rr_interconnect_if: request/ack bus bundle around the shared-FPU interconnect.
// Carries the N packed master-side channels and the single slave-side channel.
// Modport 'slave' is the interconnect's own view (it serves the requesters).
// Modport 'master' is the surrounding environment's view (requesters plus FPU core).
interface fpu_rr_interconnect_if #(
  parameter int NUM_MASTERS = 4,
  parameter int DATA_W      = 25,
  parameter int IDX_W       = $clog2(NUM_MASTERS)
);
  logic [NUM_MASTERS-1:0]        M_req;
  logic [NUM_MASTERS*DATA_W-1:0] M_Data1;
  logic [NUM_MASTERS*DATA_W-1:0] M_Data2;
  logic [DATA_W-1:0]             M_Dataout;
  logic [NUM_MASTERS-1:0]        M_ack;
  logic                          M_err;
  logic                          S_req;
  logic [DATA_W-1:0]             S_Data1;
  logic [DATA_W-1:0]             S_Data2;
  logic [DATA_W-1:0]             S_Datain;
  logic                          S_ack;
  logic [IDX_W-1:0]              Select;

  modport slave (
    input  M_req, M_Data1, M_Data2, S_Datain, S_ack,
    output M_Dataout, M_ack, M_err, S_req, S_Data1, S_Data2, Select
  );

  modport master (
    output M_req, M_Data1, M_Data2, S_Datain, S_ack,
    input  M_Dataout, M_ack, M_err, S_req, S_Data1, S_Data2, Select
  );
endinterface

// File: rtl/fpu_rr_interconnect.sv
// fpu_rr_interconnect: shares one FPU arithmetic slave among NUM_MASTERS requesters.
// Round-robin grant, registered operand/result paths, one transaction in flight,
// abort when the granted master withdraws its request.
// Optional feature: define FPU_IC_TIMEOUT_EN to abort a REQ phase after
// TIMEOUT_CYC cycles without S_ack; the master then gets its ack with M_err=1.
module fpu_rr_interconnect #(
  parameter int NUM_MASTERS = 4,
  parameter int DATA_W      = 25,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                  CLK,
  input  logic                  RST,
  fpu_rr_interconnect_if.slave  bus
);

  localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t            state_reg,      state_next;
  logic [IDX_W-1:0]  last_grant_reg, last_grant_next;
  logic [IDX_W-1:0]  select_reg,     select_next;
  logic              s_req_reg,      s_req_next;
  logic [DATA_W-1:0] s_data1_reg,    s_data1_next;
  logic [DATA_W-1:0] s_data2_reg,    s_data2_next;
  logic [DATA_W-1:0] result_reg,     result_next;

`ifdef FPU_IC_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  logic [CNT_W-1:0]  tmo_cnt_reg,    tmo_cnt_next;
  logic              err_reg,        err_next;
`endif

  // Per-master operand views of the packed input buses.
  logic [DATA_W-1:0] m_data1_arr [NUM_MASTERS];
  logic [DATA_W-1:0] m_data2_arr [NUM_MASTERS];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_MASTERS; gi++) begin : g_unpack
      assign m_data1_arr[gi] = bus.M_Data1[gi*DATA_W +: DATA_W];
      assign m_data2_arr[gi] = bus.M_Data2[gi*DATA_W +: DATA_W];
    end
  endgenerate

  logic [IDX_W-1:0] winner;
  logic             any_req;

  // Round-robin search: first requester after last_grant, wrapping modulo N.
  always_comb begin
    winner  = '0;
    any_req = 1'b0;
    for (int k = NUM_MASTERS; k >= 1; k--) begin
      logic [IDX_W-1:0] cand;
      cand = IDX_W'((int'(last_grant_reg) + k) % NUM_MASTERS);
      if (bus.M_req[cand]) begin
        winner  = cand;
        any_req = 1'b1;
      end
    end
  end

  // State and datapath registers; async reset puts master 0 first in line.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_reg      <= S_IDLE;
      last_grant_reg <= IDX_W'(NUM_MASTERS - 1);
      select_reg     <= '0;
      s_req_reg      <= 1'b0;
      s_data1_reg    <= '0;
      s_data2_reg    <= '0;
      result_reg     <= '0;
`ifdef FPU_IC_TIMEOUT_EN
      tmo_cnt_reg    <= '0;
      err_reg        <= 1'b0;
`endif
    end else begin
      state_reg      <= state_next;
      last_grant_reg <= last_grant_next;
      select_reg     <= select_next;
      s_req_reg      <= s_req_next;
      s_data1_reg    <= s_data1_next;
      s_data2_reg    <= s_data2_next;
      result_reg     <= result_next;
`ifdef FPU_IC_TIMEOUT_EN
      tmo_cnt_reg    <= tmo_cnt_next;
      err_reg        <= err_next;
`endif
    end
  end

  // Next-state logic: grant in IDLE, wait for ack or withdrawal in REQ, one-cycle RESP.
  always_comb begin
    state_next      = state_reg;
    last_grant_next = last_grant_reg;
    select_next     = select_reg;
    s_req_next      = s_req_reg;
    s_data1_next    = s_data1_reg;
    s_data2_next    = s_data2_reg;
    result_next     = result_reg;
`ifdef FPU_IC_TIMEOUT_EN
    tmo_cnt_next    = tmo_cnt_reg;
    err_next        = err_reg;
`endif
    case (state_reg)
      S_IDLE: begin
        if (any_req) begin
          select_next     = winner;
          last_grant_next = winner;
          s_data1_next    = m_data1_arr[winner];
          s_data2_next    = m_data2_arr[winner];
          s_req_next      = 1'b1;
          state_next      = S_REQ;
`ifdef FPU_IC_TIMEOUT_EN
          tmo_cnt_next    = '0;
          err_next        = 1'b0;
`endif
        end
      end
      S_REQ: begin
        // Withdrawal wins over an ack arriving on the same edge.
        if (!bus.M_req[select_reg]) begin
          s_req_next = 1'b0;
          state_next = S_IDLE;
        end else if (bus.S_ack) begin
          result_next = bus.S_Datain;
          s_req_next  = 1'b0;
          state_next  = S_RESP;
`ifdef FPU_IC_TIMEOUT_EN
        end else if (tmo_cnt_reg == CNT_W'(TIMEOUT_CYC - 1)) begin
          result_next = '0;
          s_req_next  = 1'b0;
          err_next    = 1'b1;
          state_next  = S_RESP;
        end else begin
          tmo_cnt_next = tmo_cnt_reg + 1'b1;
`endif
        end
      end
      S_RESP: begin
        state_next = S_IDLE;
`ifdef FPU_IC_TIMEOUT_EN
        err_next   = 1'b0;
`endif
      end
      default: begin
        state_next = S_IDLE;
        s_req_next = 1'b0;
      end
    endcase
  end

  logic [NUM_MASTERS-1:0] ack_vec;

  // One-hot completion pulse to the granted master during RESP only.
  always_comb begin
    ack_vec = '0;
    if (state_reg == S_RESP) begin
      ack_vec[select_reg] = 1'b1;
    end
  end

  assign bus.M_ack     = ack_vec;
  assign bus.M_Dataout = (state_reg == S_RESP) ? result_reg : '0;
  assign bus.S_req     = s_req_reg;
  assign bus.S_Data1   = s_data1_reg;
  assign bus.S_Data2   = s_data2_reg;
  assign bus.Select    = select_reg;
`ifdef FPU_IC_TIMEOUT_EN
  assign bus.M_err     = (state_reg == S_RESP) && err_reg;
`else
  assign bus.M_err     = 1'b0;
`endif

endmodule

// File: tb/tb_fpu_rr_interconnect.sv
// tb_fpu_rr_interconnect: directed bench for the shared-FPU interconnect.
// Expected completions are queued when a request is driven and checked when M_ack fires.
// The slave model returns S_Data1 + S_Data2; expectations use the bench's own operand table.
module tb_fpu_rr_interconnect;
  localparam int N    = 4;
  localparam int DW   = 25;
  localparam int TCYC = 8;

  logic CLK = 1'b0;
  logic RST;

  always #5 CLK = ~CLK;

  fpu_rr_interconnect_if #(.NUM_MASTERS(N), .DATA_W(DW)) bus ();

  fpu_rr_interconnect #(.NUM_MASTERS(N), .DATA_W(DW), .TIMEOUT_CYC(TCYC)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  typedef struct {
    int          idx;
    logic [DW-1:0] data;
    logic        err;
  } exp_t;

  exp_t          sb [$];
  int            checks = 0;
  int            errors = 0;
  logic [DW-1:0] op1 [N];
  logic [DW-1:0] op2 [N];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(negedge CLK);
  endtask

  task automatic push_exp(input int idx, input logic err);
    exp_t e;
    e.idx  = idx;
    e.err  = err;
    e.data = err ? '0 : DW'(op1[idx] + op2[idx]);
    sb.push_back(e);
  endtask

  task automatic check_ack(input string tag);
    exp_t e;
    logic [N-1:0] oh;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 64'd1, 64'd0);
      return;
    end
    e  = sb.pop_front();
    oh = N'(1) << e.idx;
    chk({tag, "_ack"},  bus.M_ack,     oh);
    chk({tag, "_data"}, bus.M_Dataout, e.data);
    chk({tag, "_err"},  bus.M_err,     e.err);
    $display("txn %s master=%0d data=%0h err=%0b", tag, e.idx, bus.M_Dataout, bus.M_err);
  endtask

  // Wait for grant, let the slave answer after 'delay' cycles, check the completion.
  task automatic do_txn(input string tag, input int delay);
    int w;
    w = 0;
    while (bus.S_req !== 1'b1 && w < 20) begin
      tick();
      w++;
    end
    if (bus.S_req !== 1'b1) begin
      chk({tag, "_grant_timeout"}, 64'd0, 64'd1);
      return;
    end
    if (sb.size() > 0) chk({tag, "_select"}, bus.Select, sb[0].idx);
    repeat (delay - 1) tick();
    bus.S_Datain = bus.S_Data1 + bus.S_Data2;
    bus.S_ack    = 1'b1;
    tick();
    bus.S_ack    = 1'b0;
    bus.S_Datain = '0;
    chk({tag, "_sreq_low"}, bus.S_req, 0);
    check_ack(tag);
    tick();
    chk({tag, "_ack_one_cycle"}, bus.M_ack, 0);
  endtask

  initial begin
    int cyc;
    RST          = 1'b1;
    bus.M_req    = '0;
    bus.M_Data1  = '0;
    bus.M_Data2  = '0;
    bus.S_Datain = '0;
    bus.S_ack    = 1'b0;
    for (int i = 0; i < N; i++) begin
      op1[i] = DW'(32'h10000 + 32'h111 * i);
      op2[i] = DW'(32'h1000 * (i + 1));
    end
    op1[1] = 25'h1;
    op2[1] = 25'h2;
    for (int i = 0; i < N; i++) begin
      bus.M_Data1[i*DW +: DW] = op1[i];
      bus.M_Data2[i*DW +: DW] = op2[i];
    end

    // Reset values
    repeat (2) tick();
    chk("rst_sreq",    bus.S_req,     0);
    chk("rst_ack",     bus.M_ack,     0);
    chk("rst_select",  bus.Select,    0);
    chk("rst_dataout", bus.M_Dataout, 0);
    chk("rst_err",     bus.M_err,     0);
    RST = 1'b0;
    tick();

    // Round-robin with all masters requesting, immediate slave ack
    bus.M_req = 4'b1111;
    push_exp(0, 1'b0); push_exp(1, 1'b0); push_exp(2, 1'b0);
    push_exp(3, 1'b0); push_exp(0, 1'b0);
    for (int k = 0; k < 5; k++) do_txn("rr", 1);
    bus.M_req = '0;

    // Single request from master 1, slave acks 3 cycles after grant
    bus.M_req = 4'b0010;
    push_exp(1, 1'b0);
    tick();
    chk("single_sdata1", bus.S_Data1, 25'h1);
    chk("single_sdata2", bus.S_Data2, 25'h2);
    do_txn("single", 3);
    bus.M_req = '0;

    // Stray S_ack while idle has no effect
    bus.S_ack    = 1'b1;
    bus.S_Datain = 25'h1ABCD;
    tick();
    bus.S_ack    = 1'b0;
    bus.S_Datain = '0;
    chk("stray_ack",  bus.M_ack, 0);
    chk("stray_sreq", bus.S_req, 0);
    tick();
    chk("stray_ack2", bus.M_ack, 0);

    // Wrap: move last_grant to 3, then masters 0 and 3 compete
    bus.M_req = 4'b1000;
    push_exp(3, 1'b0);
    do_txn("wrap_pre", 1);
    bus.M_req = 4'b1001;
    push_exp(0, 1'b0);
    push_exp(3, 1'b0);
    do_txn("wrap_m0", 2);
    bus.M_req = 4'b1000;
    do_txn("wrap_m3", 1);
    bus.M_req = '0;

    // Abort: master 2 withdraws on the same edge the slave acks
    bus.M_req = 4'b0100;
    tick();
    chk("abort_select", bus.Select, 2);
    chk("abort_sreq",   bus.S_req,  1);
    bus.M_req    = 4'b0001;
    bus.S_ack    = 1'b1;
    bus.S_Datain = 25'h155;
    tick();
    bus.S_ack    = 1'b0;
    bus.S_Datain = '0;
    chk("abort_sreq_low", bus.S_req, 0);
    chk("abort_no_ack",   bus.M_ack, 0);
    tick();
    chk("abort_no_ack2",  bus.M_ack, 0);
    push_exp(0, 1'b0);
    do_txn("abort_next", 2);
    bus.M_req = '0;

    // Async reset during REQ, then master 0 has priority again
    bus.M_req = 4'b0100;
    tick();
    chk("arst_pre_sreq", bus.S_req, 1);
    #2 RST = 1'b1;
    #1;
    chk("arst_sreq",   bus.S_req,  0);
    chk("arst_select", bus.Select, 0);
    chk("arst_ack",    bus.M_ack,  0);
    bus.M_req = 4'b1001;
    repeat (2) tick();
    chk("arst_hold_sreq", bus.S_req, 0);
    RST = 1'b0;
    push_exp(0, 1'b0);
    do_txn("arst_m0", 1);
    bus.M_req = 4'b1000;
    push_exp(3, 1'b0);
    do_txn("arst_m3", 1);
    bus.M_req = '0;

`ifdef FPU_IC_TIMEOUT_EN
    // Timeout: slave never answers
    tick();
    bus.M_req = 4'b0001;
    push_exp(0, 1'b1);
    tick();
    cyc = 0;
    while (bus.S_req === 1'b1 && cyc < 20) begin
      cyc++;
      tick();
    end
    chk("tmo_sreq_cycles", cyc, TCYC);
    check_ack("tmo");
    bus.M_req = '0;
    tick();
    chk("tmo_ack_one_cycle", bus.M_ack, 0);
`else
    cyc = 0;
`endif

    chk("sb_drained", sb.size(), cyc * 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
